// File: rtl/automata_pkg.sv
// Shared types and helpers for the cellular-automaton datapath blocks.
package automata_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LAST = 2'd2
    } cawb_state_t;

    // Index width for a row of n chunks; never narrower than one bit.
    function automatic int cawb_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ca_window_buffer_if.sv
// Chunk-in / window-out stream bundle for ca_window_buffer.
interface ca_window_buffer_if #(
    parameter int CHUNK_W = 20,
    parameter int HALO    = 1,
    parameter int IDX_W   = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHUNK_W-1:0]        din;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHUNK_W+2*HALO-1:0] dout;
    logic                      out_first;
    logic                      out_last;
    logic [IDX_W-1:0]          out_idx;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout, out_first, out_last, out_idx
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout, out_first, out_last, out_idx
    );
endinterface

// File: rtl/ca_window_buffer.sv
// Turns a row of CHUNK_W-bit chunks into windows carrying HALO neighbour
// cells on each side, with edge fill at the row boundaries.
module ca_window_buffer
    import automata_pkg::*;
#(
    parameter int   CHUNK_W        = 20,
    parameter int   HALO           = 1,
    parameter int   CHUNKS_PER_ROW = 32,
    parameter logic EDGE_FILL      = 1'b0
) (
    input logic              clk,
    input logic              clear_n,
    input logic              flush,
    ca_window_buffer_if.slave bus
);

    localparam int IDX_W = cawb_idx_w(CHUNKS_PER_ROW);
    localparam int WIN_W = CHUNK_W + 2 * HALO;
    localparam logic [HALO-1:0]  FILL_BITS = {HALO{EDGE_FILL}};
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHUNKS_PER_ROW - 1);

    cawb_state_t        state_q, state_d;
    logic [CHUNK_W-1:0] cur_q, cur_d;
    logic [HALO-1:0]    lhalo_q, lhalo_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_inc;
    logic [WIN_W-1:0]   dout_q, dout_d;
    logic               out_valid_q, out_valid_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

    logic slot_free;
    logic in_ready;
    logic accept;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_ready  = clear_n && !flush &&
                       ((state_q == IDLE) || ((state_q == HOLD) && slot_free));
    assign accept    = bus.in_valid && in_ready;
    assign idx_inc   = idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        lhalo_d     = lhalo_q;
        idx_d       = idx_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_d   = bus.din;
                        lhalo_d = FILL_BITS;
                        idx_d   = '0;
                        state_d = (CHUNKS_PER_ROW == 1) ? LAST : HOLD;
                    end
                end
                HOLD: begin
                    // The incoming chunk supplies the right halo of the held one.
                    if (accept) begin
                        dout_d      = {lhalo_q, cur_q, bus.din[CHUNK_W-1 -: HALO]};
                        out_valid_d = 1'b1;
                        out_idx_d   = idx_q;
                        out_first_d = (idx_q == '0);
                        out_last_d  = 1'b0;
                        lhalo_d     = cur_q[HALO-1:0];
                        cur_d       = bus.din;
                        idx_d       = idx_inc;
                        if (idx_inc == LAST_IDX) begin
                            state_d = LAST;
                        end
                    end
                end
                LAST: begin
                    if (slot_free) begin
                        dout_d      = {lhalo_q, cur_q, FILL_BITS};
                        out_valid_d = 1'b1;
                        out_idx_d   = idx_q;
                        out_first_d = (idx_q == '0);
                        out_last_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Held cells are always rewritten on the first accept of a row.
    always_ff @(posedge clk) begin
        cur_q   <= cur_d;
        lhalo_q <= lhalo_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_ca_window_buffer.sv
// Directed scoreboard bench for ca_window_buffer over three configurations.
module tb_ca_window_buffer;

    typedef struct {
        logic [7:0] dout;
        logic       first;
        logic       last;
        logic [1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic flush_c = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;

    ca_window_buffer_if #(.CHUNK_W(4), .HALO(1), .IDX_W(2)) ia ();
    ca_window_buffer_if #(.CHUNK_W(4), .HALO(1), .IDX_W(1)) ib ();
    ca_window_buffer_if #(.CHUNK_W(4), .HALO(2), .IDX_W(1)) ic ();

    ca_window_buffer #(.CHUNK_W(4), .HALO(1), .CHUNKS_PER_ROW(3), .EDGE_FILL(1'b0))
        dut_a (.clk(clk), .clear_n(clear_n), .flush(flush_a), .bus(ia));
    ca_window_buffer #(.CHUNK_W(4), .HALO(1), .CHUNKS_PER_ROW(1), .EDGE_FILL(1'b1))
        dut_b (.clk(clk), .clear_n(clear_n), .flush(flush_b), .bus(ib));
    ca_window_buffer #(.CHUNK_W(4), .HALO(2), .CHUNKS_PER_ROW(2), .EDGE_FILL(1'b0))
        dut_c (.clk(clk), .clear_n(clear_n), .flush(flush_c), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input string tag, input logic [7:0] d, input logic f,
                       input logic l, input logic [1:0] i, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected_window"}, {24'd0, d}, 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            chk({tag, "_dout"}, {24'd0, d}, {24'd0, e.dout});
            chk({tag, "_first"}, {31'd0, f}, {31'd0, e.first});
            chk({tag, "_last"}, {31'd0, l}, {31'd0, e.last});
            chk({tag, "_idx"}, {30'd0, i}, {30'd0, e.idx});
        end
    endtask

    always @(negedge clk) begin
        if (ia.out_valid && ia.out_ready)
            mon("a", {2'b00, ia.dout}, ia.out_first, ia.out_last, ia.out_idx, qa);
        if (ib.out_valid && ib.out_ready)
            mon("b", {2'b00, ib.dout}, ib.out_first, ib.out_last, {1'b0, ib.out_idx}, qb);
        if (ic.out_valid && ic.out_ready)
            mon("c", ic.dout, ic.out_first, ic.out_last, {1'b0, ic.out_idx}, qc);
    end

    task automatic push(input int sel, input logic [7:0] d, input logic f,
                        input logic l, input logic [1:0] i);
        exp_t e;
        e = '{dout: d, first: f, last: l, idx: i};
        case (sel)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Offer one chunk and return just after the edge that accepts it.
    task automatic send(input int sel, input logic [3:0] d);
        int   n;
        logic rdy;
        n = 0;
        case (sel)
            0: begin ia.in_valid = 1'b1; ia.din = d; end
            1: begin ib.in_valid = 1'b1; ib.din = d; end
            default: begin ic.in_valid = 1'b1; ic.din = d; end
        endcase
        do begin
            @(negedge clk);
            n++;
            case (sel)
                0: rdy = ia.in_ready;
                1: rdy = ib.in_ready;
                default: rdy = ic.in_ready;
            endcase
        end while (!rdy && n < 50);
        chk("send_accept_timeout", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
        ic.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n < 100}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic row_a_basic();
        push(0, 8'b010010, 1'b1, 1'b0, 2'd0);
        push(0, 8'b101101, 1'b0, 1'b0, 2'd1);
        push(0, 8'b011110, 1'b0, 1'b1, 2'd2);
        send(0, 4'b1001);
        send(0, 4'b0110);
        send(0, 4'b1111);
        @(negedge clk);
        chk("a_in_ready_last_bubble", {31'd0, ia.in_ready}, 32'd0);
        @(negedge clk);
        chk("a_in_ready_after_bubble", {31'd0, ia.in_ready}, 32'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.in_valid = 1'b0; ia.din = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.din = '0; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.din = '0; ic.out_ready = 1'b1;

        #1;
        chk("rst_a_out_valid", {31'd0, ia.out_valid}, 32'd0);
        chk("rst_a_dout", {26'd0, ia.dout}, 32'd0);
        chk("rst_a_tags", {28'd0, ia.out_first, ia.out_last, ia.out_idx}, 32'd0);
        chk("rst_a_in_ready", {31'd0, ia.in_ready}, 32'd0);
        chk("rst_b_out_valid", {31'd0, ib.out_valid}, 32'd0);
        chk("rst_c_dout", {24'd0, ic.dout}, 32'd0);
        #17 clear_n = 1'b1;
        @(posedge clk);
        #1;

        row_a_basic();

        // Backpressure: hold window 0 for five cycles with a chunk on offer.
        push(0, 8'b010010, 1'b1, 1'b0, 2'd0);
        push(0, 8'b101101, 1'b0, 1'b0, 2'd1);
        push(0, 8'b011110, 1'b0, 1'b1, 2'd2);
        send(0, 4'b1001);
        ia.out_ready = 1'b0;
        send(0, 4'b0110);
        ia.in_valid = 1'b1;
        ia.din = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_dout_hold", {26'd0, ia.dout}, 32'b010010);
            chk("bp_out_valid", {31'd0, ia.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, ia.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 ia.out_ready = 1'b1;
        send(0, 4'b1111);
        drain();

        // Single-chunk rows with edge fill of one.
        push(1, 8'b110101, 1'b1, 1'b1, 2'd0);
        send(1, 4'b1010);
        drain();

        // Two-cell halo, two chunks per row.
        push(2, 8'b00110101, 1'b1, 1'b0, 2'd0);
        push(2, 8'b01011100, 1'b0, 1'b1, 2'd1);
        send(2, 4'b1101);
        send(2, 4'b0111);
        drain();

        // Flush mid-row with window 0 still unconsumed.
        send(0, 4'b1001);
        ia.out_ready = 1'b0;
        send(0, 4'b0110);
        flush_a = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_low", {31'd0, ia.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush_a = 1'b0;
        ia.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, ia.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, ia.in_ready}, 32'd1);
        push(0, 8'b001101, 1'b1, 1'b0, 2'd0);
        push(0, 8'b011111, 1'b0, 1'b0, 2'd1);
        push(0, 8'b110010, 1'b0, 1'b1, 2'd2);
        @(posedge clk);
        #1;
        send(0, 4'b0110);
        send(0, 4'b1111);
        send(0, 4'b1001);
        drain();

        // Asynchronous clear while a window is held.
        send(0, 4'b1001);
        ia.out_ready = 1'b0;
        send(0, 4'b0110);
        ia.in_valid = 1'b1;
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("clr_out_valid", {31'd0, ia.out_valid}, 32'd0);
        chk("clr_dout", {26'd0, ia.dout}, 32'd0);
        chk("clr_tags", {28'd0, ia.out_first, ia.out_last, ia.out_idx}, 32'd0);
        chk("clr_in_ready", {31'd0, ia.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        chk("clr_in_ready_held", {31'd0, ia.in_ready}, 32'd0);
        clear_n = 1'b1;
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1;
        row_a_basic();

        chk("end_queue_a_empty", qa.size(), 32'd0);
        chk("end_queue_b_empty", qb.size(), 32'd0);
        chk("end_queue_c_empty", qc.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ca_window_buffer.md
Name: ca_window_buffer

Overview:
- Parametrised successor to the fixed 41-bit shift buffer in the cellular-automaton datapath.
- Takes a row of cells as a stream of CHUNK_W-bit chunks, leftmost chunk first.
- For each chunk it emits a window of CHUNK_W+2*HALO bits: the chunk plus HALO neighbour cells on each side, for the rule-evaluation stage.
- Valid/ready on both sides, row-edge fill, row position tags and a sync flush.

Parameters:
- CHUNK_W, 20, cells per input chunk (>=1).
- HALO, 1, neighbour cells per side (1..CHUNK_W).
- CHUNKS_PER_ROW, 32, chunks per row (>=1).
- EDGE_FILL, 1'b0, cell value for halo beyond row edges.

Ports:
- clk  in  1  clock.
- clear_n  in  1  async active-low reset.
- flush  in  1  sync abort of current row; highest priority after reset.
- in_valid  in  1  din valid.
- in_ready  out  1  buffer accepts din this cycle.
- din  in  CHUNK_W  chunk; MSB = leftmost cell.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer takes window.
- dout  out  CHUNK_W+2*HALO  {left halo, chunk, right halo}, MSB leftmost.
- out_first  out  1  window belongs to chunk 0.
- out_last  out  1  window belongs to chunk CHUNKS_PER_ROW-1.
- out_idx  out  IDX_W  chunk index of window; IDX_W = max(1, clog2(CHUNKS_PER_ROW)).

Behaviour:
- Reset (clear_n low, async): state=IDLE; out_valid, dout, out_first, out_last, out_idx all 0; in_ready forced 0 while clear_n low.
- Internal registers:
  - cur: held chunk, CHUNK_W bits.
  - lhalo: HALO bits.
  - idx: index of cur.
  - Output registers dout/out_* with out_valid.
- slot_free = !out_valid || out_ready.
- in_ready = (state==IDLE) || (state==HOLD && slot_free); 0 when flush=1.
- IDLE:
  - On accept: cur<=din; lhalo<={HALO{EDGE_FILL}}; idx<=0.
  - Next state is HOLD, or LAST if CHUNKS_PER_ROW==1.
  - No output is produced.
- HOLD, on accept (needs slot_free):
  - dout<={lhalo, cur, din[CHUNK_W-1 -: HALO]}; out_valid<=1; out_idx<=idx; out_first<=(idx==0); out_last<=0.
  - lhalo<=cur[HALO-1:0]; cur<=din; idx<=idx+1.
  - If idx+1==CHUNKS_PER_ROW-1, go to LAST.
- LAST, when slot_free (no input consumed):
  - dout<={lhalo, cur, {HALO{EDGE_FILL}}}; out_valid<=1; out_idx<=idx; out_first<=(idx==0); out_last<=1.
  - Go to IDLE.
- Output handshake:
  - If out_valid && out_ready and no new window is loaded that cycle, out_valid<=0.
  - dout and tags stay stable while out_valid && !out_ready.
- Latency:
  - The window for chunk k is registered on the cycle chunk k+1 is accepted; for the last chunk, the cycle after it is accepted (if slot_free).
  - Steady state is one chunk per cycle, with one input bubble per row (the LAST cycle).
- flush=1 (clear_n high):
  - Next edge: state=IDLE, out_valid=0, held chunk discarded.
  - Concurrent din and output transfer are ignored.
  - dout is not cleared.
- Backpressure: out_ready low in HOLD drops in_ready; no data is lost or duplicated.
- Wrap-around: idx never exceeds CHUNKS_PER_ROW-1; each new row restarts at IDLE with a fresh left-edge fill.

Decomposition:
- Shared package automata_pkg:
  - typedef enum {IDLE, HOLD, LAST} cawb_state_t.
  - Function for IDX_W (clog2 with minimum 1).
- No sub-module; window assembly is inline concatenation.

Test Plan:
- CHUNK_W=4, HALO=1, CPR=3, FILL=0; stream 1001, 0110, 1111 with out_ready=1:
  - dout=010010 (first, idx0).
  - dout=101101 (idx1).
  - dout=011110 (last, idx2).
  - in_ready low exactly one cycle after 1111.
- Same config, out_ready held 0 after first window for 5 cycles:
  - dout stays 010010; in_ready=0; no input consumed.
  - On release, remaining windows arrive in order, unchanged.
- CPR=1, FILL=1, din=1010 -> single window 110101 with out_first=out_last=1, idx0.
- CHUNK_W=4, HALO=2, CPR=2, FILL=0; din 1101, 0111 -> 00110101 then 01011100 (last).
- Mid-row abort:
  - flush after chunk 1 of 3 -> out_valid=0 next cycle, in_ready=1.
  - Next row's chunk 0 window is first with left halo = fill.
- clear_n pulsed low asynchronously mid-window:
  - Outputs zero immediately; in_ready=0 during reset.
  - After release, full row per first scenario is reproduced exactly.
